// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DEF_NUM_CH = 2;
    localparam int unsigned DEF_CNT_W  = 31;
    localparam int unsigned DEF_DIV    = 50000000;
    localparam int unsigned DEF_CMP    = DEF_DIV / 2 + 1;

    // Channel-select width, never narrower than one bit.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Run-control, config bus and output bundle of clk_div_multi.
interface clk_div_multi_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W
);

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_cmp;
    logic [NUM_CH-1:0] q;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    modport master (
        output en, sync, cfg_we, cfg_ch, cfg_div, cfg_cmp,
        input  q, tick, pend
    );

    modport slave (
        input  en, sync, cfg_we, cfg_ch, cfg_div, cfg_cmp,
        output q, tick, pend
    );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active period+threshold, registered q/tick/pend.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DIV_DEF = DEF_DIV,
    parameter int unsigned CMP_DEF = DEF_CMP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_cmp,
    output logic             q,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEF);
    localparam logic [CNT_W-1:0] CMP_RST = CNT_W'(CMP_DEF);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_act, div_act_n, cmp_act, cmp_act_n;
    logic [CNT_W-1:0] div_sh, div_sh_n, cmp_sh, cmp_sh_n;
    logic             pend_n, q_n, tick_n;
    logic             pend_eff, restart, load;

    // A write in the restart cycle is forwarded straight into the active set,
    // and q/tick are computed from next-state so they line up with cnt.
    always_comb begin
        div_sh_n  = wr ? wr_div : div_sh;
        cmp_sh_n  = wr ? wr_cmp : cmp_sh;
        pend_eff  = wr | pend;
        restart   = !en || sync || (cnt == div_act);
        load      = restart && pend_eff;
        div_act_n = load ? div_sh_n : div_act;
        cmp_act_n = load ? cmp_sh_n : cmp_act;
        pend_n    = pend_eff && !load;
        cnt_n     = restart ? '0 : cnt + CNT_W'(1);
        tick_n    = en && (cnt_n == div_act_n);
        q_n       = en && (cnt_n >= cmp_act_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            div_sh  <= DIV_RST;
            cmp_act <= CMP_RST;
            cmp_sh  <= CMP_RST;
            pend    <= 1'b0;
            q       <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div_act <= div_act_n;
            div_sh  <= div_sh_n;
            cmp_act <= cmp_act_n;
            cmp_sh  <= cmp_sh_n;
            pend    <= pend_n;
            q       <= q_n;
            tick    <= tick_n;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / tick generator; decodes the shared config bus per channel.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned DIV_DEF = DEF_DIV,
    parameter int unsigned CMP_DEF = DIV_DEF / 2 + 1
) (
    input  logic            clk,
    input  logic            rst,
    clk_div_multi_if.slave  bus
);

    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] q_w, tick_w, pend_w;

    // Out-of-range channel numbers match no entry and are dropped.
    always_comb begin
        wr = '0;
        if (bus.cfg_we) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (32'(bus.cfg_ch) == i) begin
                    wr[i] = 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_channel #(
            .CNT_W   (CNT_W),
            .DIV_DEF (DIV_DEF),
            .CMP_DEF (CMP_DEF)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (bus.en[i]),
            .sync   (bus.sync),
            .wr     (wr[i]),
            .wr_div (bus.cfg_div),
            .wr_cmp (bus.cfg_cmp),
            .q      (q_w[i]),
            .tick   (tick_w[i]),
            .pend   (pend_w[i])
        );
    end

    assign bus.q    = q_w;
    assign bus.tick = tick_w;
    assign bus.pend = pend_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed vector table, out-of-range select check, random vs model.
module tb_clk_div_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clk_div_multi_if #(.NUM_CH(2), .CNT_W(8)) bus  ();
    clk_div_multi_if #(.NUM_CH(3), .CNT_W(8)) bus3 ();

    clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DIV_DEF(9), .CMP_DEF(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DIV_DEF(9), .CMP_DEF(5)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: position within the period advances modulo (period length).
    int m_pos[2], m_div[2], m_cmp[2], m_sdiv[2], m_scmp[2];
    bit m_pend[2], m_q[2], m_tick[2];

    typedef struct {
        string    name;
        bit       rst;
        bit [1:0] en;
        bit       sync;
        bit       we;
        int       ch;
        int       div;
        int       cmp;
        int       n;
        bit [5:0] exp;   // {q[1:0], tick[1:0], pend[1:0]}
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string name, bit r, bit [1:0] en, bit s, bit we,
                                int ch, int div, int cmp, int n, bit [5:0] exp);
        vec_t v;
        v.name = name; v.rst = r; v.en = en; v.sync = s; v.we = we;
        v.ch = ch; v.div = div; v.cmp = cmp; v.n = n; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: q/tick/pend got %b required %b", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_pos[c] = 0; m_div[c] = 9; m_sdiv[c] = 9; m_cmp[c] = 5; m_scmp[c] = 5;
                m_pend[c] = 0; m_q[c] = 0; m_tick[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
                    m_sdiv[c] = int'(bus.cfg_div);
                    m_scmp[c] = int'(bus.cfg_cmp);
                    m_pend[c] = 1;
                end
                if (!bus.en[c]) begin
                    m_pos[c] = 0;
                    if (m_pend[c]) begin
                        m_div[c] = m_sdiv[c]; m_cmp[c] = m_scmp[c]; m_pend[c] = 0;
                    end
                    m_q[c] = 0; m_tick[c] = 0;
                end else begin
                    m_pos[c] = bus.sync ? 0 : (m_pos[c] + 1) % (m_div[c] + 1);
                    if (m_pos[c] == 0 && m_pend[c]) begin
                        m_div[c] = m_sdiv[c]; m_cmp[c] = m_scmp[c]; m_pend[c] = 0;
                    end
                    m_tick[c] = (m_pos[c] == m_div[c]);
                    m_q[c]    = (m_pos[c] >= m_cmp[c]);
                end
            end
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model", {bus.q, bus.tick, bus.pend},
              {m_q[1], m_q[0], m_tick[1], m_tick[0], m_pend[1], m_pend[0]});
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst         = v.rst;
        bus.en      = v.en;
        bus.sync    = v.sync;
        bus.cfg_we  = v.we;
        bus.cfg_ch  = 1'(v.ch);
        bus.cfg_div = 8'(v.div);
        bus.cfg_cmp = 8'(v.cmp);
        for (int i = 0; i < v.n; i++) begin
            step_cycle();
            if (i == 0) begin
                bus.sync   = 1'b0;
                bus.cfg_we = 1'b0;
            end
        end
        check(v.name, {bus.q, bus.tick, bus.pend}, v.exp);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = '0; bus.sync = 0; bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_div = '0; bus.cfg_cmp = '0;
        bus3.en = 3'b111; bus3.sync = 0; bus3.cfg_we = 0; bus3.cfg_ch = '0;
        bus3.cfg_div = '0; bus3.cfg_cmp = '0;

        // Three-channel instance: select 3 is out of range, select 2 is not.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus3.cfg_we = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_div = 8'd1; bus3.cfg_cmp = 8'd0;
        @(posedge clk); #1;
        check("ch_oob_ignored", {3'b000, bus3.pend}, 6'b000000);
        bus3.cfg_ch = 2'd2;
        @(posedge clk); #1;
        check("ch2_pend", {3'b000, bus3.pend}, 6'b000100);
        bus3.cfg_we = 1'b0;

        vt.push_back(mk("reset",          1, 2'b00, 0, 0, 0, 0, 0, 2, 6'b00_00_00));
        vt.push_back(mk("first_tick",     0, 2'b11, 0, 0, 0, 0, 0, 9, 6'b11_11_00));
        vt.push_back(mk("wrap0",          0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b00_00_00));
        vt.push_back(mk("half_high",      0, 2'b11, 0, 0, 0, 0, 0, 5, 6'b11_00_00));
        vt.push_back(mk("wr_mid_pend",    0, 2'b11, 0, 1, 0, 3, 1, 1, 6'b11_00_01));
        vt.push_back(mk("pend_held",      0, 2'b11, 0, 0, 0, 0, 0, 3, 6'b11_11_01));
        vt.push_back(mk("pend_loaded",    0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b00_00_00));
        vt.push_back(mk("new_cmp",        0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b01_00_00));
        vt.push_back(mk("new_period",     0, 2'b11, 0, 0, 0, 0, 0, 2, 6'b01_01_00));
        vt.push_back(mk("ch1_at_wrap",    0, 2'b11, 0, 0, 0, 0, 0, 6, 6'b11_10_00));
        vt.push_back(mk("wr_on_wrap",     0, 2'b11, 0, 1, 1, 4, 2, 1, 6'b01_00_00));
        vt.push_back(mk("fwd_period5",    0, 2'b11, 0, 0, 0, 0, 0, 4, 6'b11_10_00));
        vt.push_back(mk("fwd_wrap",       0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b01_01_00));
        vt.push_back(mk("run10",          0, 2'b11, 0, 0, 0, 0, 0, 10, 6'b01_00_00));
        vt.push_back(mk("wr_div0",        0, 2'b11, 0, 1, 0, 0, 0, 1, 6'b01_00_01));
        vt.push_back(mk("div0_pending",   0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b11_01_01));
        vt.push_back(mk("div0_active",    0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b11_01_00));
        vt.push_back(mk("div0_steady",    0, 2'b11, 0, 0, 0, 0, 0, 3, 6'b01_01_00));
        vt.push_back(mk("cmp_gt_div",     0, 2'b11, 0, 1, 0, 3, 5, 1, 6'b10_00_00));
        vt.push_back(mk("q_stuck0_tick",  0, 2'b11, 0, 0, 0, 0, 0, 3, 6'b00_01_00));
        vt.push_back(mk("both_tick",      0, 2'b11, 0, 0, 0, 0, 0, 4, 6'b10_11_00));
        vt.push_back(mk("offset",         0, 2'b11, 0, 0, 0, 0, 0, 6, 6'b00_00_00));
        vt.push_back(mk("sync_no_tick",   0, 2'b11, 1, 0, 0, 0, 0, 1, 6'b00_00_00));
        vt.push_back(mk("post_sync3",     0, 2'b11, 0, 0, 0, 0, 0, 3, 6'b10_01_00));
        vt.push_back(mk("post_sync4",     0, 2'b11, 0, 0, 0, 0, 0, 1, 6'b10_10_00));
        vt.push_back(mk("wr_cmp1",        0, 2'b11, 0, 1, 0, 3, 1, 1, 6'b00_00_01));
        vt.push_back(mk("cmp1_wait",      0, 2'b11, 0, 0, 0, 0, 0, 2, 6'b10_01_01));
        vt.push_back(mk("cmp1_live",      0, 2'b11, 0, 0, 0, 0, 0, 2, 6'b11_10_00));
        vt.push_back(mk("en0_off",        0, 2'b10, 0, 0, 0, 0, 0, 1, 6'b00_00_00));
        vt.push_back(mk("pend_before_rst",0, 2'b10, 0, 1, 1, 7, 2, 1, 6'b00_00_10));
        vt.push_back(mk("rst_mid",        1, 2'b10, 0, 0, 0, 0, 0, 1, 6'b00_00_00));
        vt.push_back(mk("div_restored",   0, 2'b11, 0, 0, 0, 0, 0, 9, 6'b11_11_00));
        vt.push_back(mk("pend_discarded", 0, 2'b11, 0, 0, 0, 0, 0, 8, 6'b11_00_00));

        foreach (vt[k]) apply(vt[k]);

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 199) == 0);
            bus.en[0]   = ($urandom_range(0, 15) != 0);
            bus.en[1]   = ($urandom_range(0, 15) != 0);
            bus.sync    = ($urandom_range(0, 19) == 0);
            bus.cfg_we  = ($urandom_range(0, 5) == 0);
            bus.cfg_ch  = 1'($urandom_range(0, 1));
            bus.cfg_div = 8'($urandom_range(0, 12));
            bus.cfg_cmp = 8'($urandom_range(0, 14));
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
